// File: rtl/msk_ser_pkg.sv
// msk_ser_pkg: shared constants and state encoding for the masked ciphertext serializer
package msk_ser_pkg;
  localparam int NWORDS = 4;
  localparam int WORD_BITS = 32;
  localparam int CNT_W = 2;
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/msk_ser_word_mux.sv
// msk_ser_word_mux: selects one shared word from the block buffer and gates it to zero when invalid
// MSK_SER_SHIFT_ZEROIZE_EN: word is always taken from the bottom of a shifting buffer
module msk_ser_word_mux
  import msk_ser_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [NWORDS*WORD_BITS*d-1:0] data_buf,
  input  logic [CNT_W-1:0]              cnt,
  input  logic                          word_valid,
  output logic [WORD_BITS*d-1:0]        sh_word
);
  localparam int W = WORD_BITS * d;
  localparam logic [W-1:0] ZERO = '0;
  logic [W-1:0] sel;
`ifdef MSK_SER_SHIFT_ZEROIZE_EN
  assign sel = data_buf[W-1:0];
  logic unused_bits;
  assign unused_bits = ^{cnt, data_buf[NWORDS*W-1:W]};
`else
  assign sel = data_buf[int'(cnt)*W +: W];
`endif
  // per-bit select against a zero constant keeps every share on its own wire
  assign sh_word = word_valid ? sel : ZERO;
endmodule

// File: rtl/msk_cipher_out_serializer.sv
// msk_cipher_out_serializer: captures a 128-bit masked ciphertext and streams it as four shared words
// MSK_SER_SHIFT_ZEROIZE_EN: buffer shifts out and erases each word once it is accepted
module msk_cipher_out_serializer
  import msk_ser_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cipher_valid,
  output logic                          out_ready,
  input  logic [NWORDS*WORD_BITS*d-1:0] sh_ciphertext,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [WORD_BITS*d-1:0]        sh_word,
  output logic                          word_last,
  output logic                          busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [NWORDS*WORD_BITS*d-1:0] data_buf;
  assign out_ready = ~rst & (state == IDLE);
  assign word_valid = state == SEND;
  assign busy = word_valid;
  assign word_last = word_valid & (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      data_buf <= '0;
    end else if (state == IDLE) begin
      if (cipher_valid) begin
        data_buf <= sh_ciphertext;
        cnt <= '0;
        state <= SEND;
      end
    end else if (word_ready) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        data_buf <= '0;
        state <= IDLE;
      end
`ifdef MSK_SER_SHIFT_ZEROIZE_EN
      else data_buf <= data_buf >> (WORD_BITS * d);
`endif
    end
  end
  msk_ser_word_mux #(.d(d)) u_mux (
    .data_buf(data_buf),
    .cnt(cnt),
    .word_valid(word_valid),
    .sh_word(sh_word)
  );
endmodule

// File: tb/tb_msk_cipher_out_serializer.sv
// tb_msk_cipher_out_serializer: directed checks of capture, streaming, backpressure and reset
module tb_msk_cipher_out_serializer;
  localparam int D = 2;
  logic clk = 0, rst = 1, cipher_valid = 0, word_ready = 0;
  logic out_ready, word_valid, word_last, busy;
  logic [128*D-1:0] sh_ct = '0;
  logic [32*D-1:0] sh_word;
  int total = 0, bad = 0;
  logic [127:0] c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] c2 = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] c3 = 128'hdeadbeef0123456789abcdeffedcba98;
  logic [127:0] c4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  logic [31:0] w1 [4] = '{32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
  logic [255:0] pk;

  always #5 clk = ~clk;

  msk_cipher_out_serializer #(.d(D)) dut (
    .clk(clk), .rst(rst), .cipher_valid(cipher_valid), .out_ready(out_ready),
    .sh_ciphertext(sh_ct), .word_valid(word_valid), .word_ready(word_ready),
    .sh_word(sh_word), .word_last(word_last), .busy(busy)
  );

  function automatic logic [255:0] pack(input logic [127:0] ct);
    logic [127:0] s0 = {$urandom, $urandom, $urandom, $urandom};
    logic [255:0] r;
    for (int i = 0; i < 128; i++) begin
      r[2*i] = s0[i];
      r[2*i+1] = s0[i] ^ ct[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] recomb(input logic [63:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[2*i] ^ w[2*i+1];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // entered at a negedge with word 0 on the bus; stall_at<0 means no backpressure
  task automatic stream(input logic [255:0] p, input logic [127:0] ct, input int stall_at);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        word_ready = 0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_word", sh_word, p[k*64 +: 64]);
          chk("stall_last", word_last, 1'b0);
          chk("stall_cnt", dut.cnt, k);
          chk("stall_valid", word_valid, 1'b1);
        end
        word_ready = 1;
      end
      chk("word_valid", word_valid, 1'b1);
      chk("word_shares", sh_word, p[k*64 +: 64]);
      chk("word_value", recomb(sh_word), ct[k*32 +: 32]);
      chk("word_last", word_last, k == 3);
      chk("busy", busy, 1'b1);
      chk("out_ready_send", out_ready, 1'b0);
      @(negedge clk);
`ifdef MSK_SER_SHIFT_ZEROIZE_EN
      if (k < 3) chk("zeroize_top", dut.data_buf >> (256 - (k + 1) * 64), 256'd0);
`endif
    end
    chk("idle_out_ready", out_ready, 1'b1);
    chk("idle_valid", word_valid, 1'b0);
    chk("idle_word", sh_word, 64'd0);
    chk("idle_last", word_last, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_ready", out_ready, 1'b0);
    rst = 0;
    @(negedge clk);
    chk("rst_out_ready_after", out_ready, 1'b1);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_word", sh_word, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", word_last, 1'b0);
    // single block with hand-computed little-endian word order
    pk = pack(c1);
    sh_ct = pk;
    cipher_valid = 1;
    word_ready = 1;
    @(negedge clk);
    cipher_valid = 0;
    sh_ct = '0;
    for (int k = 0; k < 4; k++) begin
      chk("c1_word", recomb(sh_word), w1[k]);
      chk("c1_last", word_last, k == 3);
      @(negedge clk);
    end
    chk("c1_out_ready", out_ready, 1'b1);
    chk("c1_idle_word", sh_word, 64'd0);
    // backpressure on word 2
    pk = pack(c2);
    sh_ct = pk;
    cipher_valid = 1;
    @(negedge clk);
    cipher_valid = 0;
    stream(pk, c2, 2);
    // back-to-back blocks with cipher_valid held high
    pk = pack(c3);
    sh_ct = pk;
    cipher_valid = 1;
    begin
      logic [255:0] pk4 = pack(c4);
      int nwords = 0;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (n == 1) sh_ct = pk4;
        if (n == 9) cipher_valid = 0;
        if (n <= 4) begin
          chk("b2b_valid_a", word_valid, 1'b1);
          chk("b2b_word_a", recomb(sh_word), c3[(n-1)*32 +: 32]);
          chk("b2b_last_a", word_last, n == 4);
        end else if (n >= 6 && n <= 9) begin
          chk("b2b_valid_b", word_valid, 1'b1);
          chk("b2b_word_b", sh_word, pk4[(n-6)*64 +: 64]);
          chk("b2b_last_b", word_last, n == 9);
        end else begin
          chk("b2b_gap_valid", word_valid, 1'b0);
          chk("b2b_gap_ready", out_ready, 1'b1);
        end
        if (word_valid && word_ready) nwords++;
      end
      chk("b2b_count", nwords, 8);
    end
    // reset in the middle of a block
    pk = pack(c1);
    sh_ct = pk;
    cipher_valid = 1;
    @(negedge clk);
    cipher_valid = 0;
    chk("mid_w0", sh_word, pk[63:0]);
    @(negedge clk);
    chk("mid_w1", sh_word, pk[127:64]);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_valid", word_valid, 1'b0);
    chk("mid_buf", dut.data_buf, 256'd0);
    chk("mid_word", sh_word, 64'd0);
    chk("mid_out_ready", out_ready, 1'b0);
    rst = 0;
    @(negedge clk);
    chk("mid_recover_valid", word_valid, 1'b0);
    pk = pack(c4);
    sh_ct = pk;
    cipher_valid = 1;
    @(negedge clk);
    cipher_valid = 0;
    stream(pk, c4, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
